// File: rtl/uart_rx_bridge.sv
// 8N1 UART receiver feeding a small FIFO; presents bytes to a core using a
// send/send_ack handshake, with sticky overrun and framing-error flags.
module uart_rx_bridge #(
    parameter int unsigned WORD_WIDTH      = 32,
    parameter int unsigned CLKS_PER_BIT    = 868,
    parameter int unsigned FIFO_ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx,
    output logic                  send,
    output logic [WORD_WIDTH-1:0] data,
    input  logic                  send_ack,
    input  logic                  clear_errors,
    output logic                  overrun,
    output logic                  framing_error
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned DEPTH = 2 ** FIFO_ADDR_WIDTH;
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_ADDR_WIDTH:0] CNT_FULL = (FIFO_ADDR_WIDTH + 1)'(DEPTH);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_WAIT_IDLE = 3'd4;

    logic                       rx_meta_q, rx_s_q;
    logic [2:0]                 state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [2:0]                 idx_q, idx_d;
    logic [7:0]                 shift_q, shift_d;
    logic                       push_q, push_d;
    logic                       fe_set;
    logic                       fe_q, fe_d, ovr_q, ovr_d;
    logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_ADDR_WIDTH:0]   count_q, count_d;
    logic [7:0]                 mem [DEPTH];
    logic                       pop, full, do_push, drop;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        push_d  = 1'b0;
        fe_set  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    // Mid-start-bit recheck rejects glitches shorter than half a bit.
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == 3'd7) state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        push_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        fe_set  = 1'b1;
                        state_d = S_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_IDLE: begin
                if (rx_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign send    = (count_q != '0);
    assign pop     = send && send_ack;
    assign full    = (count_q == CNT_FULL);
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign do_push = push_q && (!full || pop);
    assign drop    = push_q && full && !pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !pop)      count_d = count_q + 1'b1;
        else if (!do_push && pop) count_d = count_q - 1'b1;
        ovr_d = drop ? 1'b1 : (clear_errors ? 1'b0 : ovr_q);
        fe_d  = fe_set ? 1'b1 : (clear_errors ? 1'b0 : fe_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            push_q    <= 1'b0;
            fe_q      <= 1'b0;
            ovr_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            push_q    <= push_d;
            fe_q      <= fe_d;
            ovr_q     <= ovr_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= shift_q;
    end

    assign data          = send ? WORD_WIDTH'(mem[rd_ptr_q]) : '0;
    assign overrun       = ovr_q;
    assign framing_error = fe_q;

endmodule

// File: tb/tb_uart_rx_bridge.sv
// Randomised bench for uart_rx_bridge: serial frames are driven on rx and the
// delivered bytes and flags are compared against a queue-based model.
module tb_uart_rx_bridge;

    localparam int unsigned CPB   = 4;
    localparam int unsigned FAW   = 4;
    localparam int unsigned DEPTH = 2 ** FAW;

    logic        clk = 1'b0;
    logic        reset, rx, send_ack, clear_errors;
    logic        send, overrun, framing_error;
    logic [31:0] data;

    int checks = 0;
    int errors = 0;

    // Model: bytes the core should see, in order, plus the expected flags.
    logic [7:0] q[$];
    logic       m_ovr = 1'b0;
    logic       m_fe  = 1'b0;

    uart_rx_bridge #(
        .WORD_WIDTH     (32),
        .CLKS_PER_BIT   (CPB),
        .FIFO_ADDR_WIDTH(FAW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .send         (send),
        .data         (data),
        .send_ack     (send_ack),
        .clear_errors (clear_errors),
        .overrun      (overrun),
        .framing_error(framing_error)
    );

    always #5 clk = ~clk;

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic frame(input logic [7:0] b, input logic stop);
        send_frame(b, stop);
        if (!stop)                 m_fe = 1'b1;
        else if (q.size() < DEPTH) q.push_back(b);
        else                       m_ovr = 1'b1;
        idle(2);
    endtask

    task automatic pulse_clear();
        clear_errors = 1'b1;
        @(negedge clk);
        clear_errors = 1'b0;
        m_ovr = 1'b0;
        m_fe  = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (send !== 1'b0) begin errors++; $display("FAIL reset_send got %b exp 0", send); end
        checks++; if (data !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", data); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b exp 0", overrun); end
        checks++; if (framing_error !== 1'b0) begin errors++; $display("FAIL reset_fe got %b exp 0", framing_error); end
    endtask

    task automatic test_single();
        frame(8'h48, 1'b1);
        idle(4);
        for (int i = 0; i < 22; i++) begin
            checks++;
            if (send !== 1'b1 || data !== 32'h48) begin
                errors++; $display("FAIL hold_%0d got send=%b data=%h exp 1/00000048", i, send, data);
            end
            @(negedge clk);
        end
        send_ack = 1'b1;
        @(negedge clk);
        send_ack = 1'b0;
        void'(q.pop_front());
        checks++;
        if (send !== 1'b0 || data !== 32'h0) begin
            errors++; $display("FAIL single_pop got send=%b data=%h exp 0/0", send, data);
        end
        // ack while empty must be ignored
        send_ack = 1'b1;
        repeat (3) @(negedge clk);
        send_ack = 1'b0;
        checks++; if (send !== 1'b0) begin errors++; $display("FAIL idle_ack got %b exp 0", send); end
    endtask

    task automatic test_back_to_back();
        frame(8'h48, 1'b1);
        frame(8'h49, 1'b1);
        frame(8'h0D, 1'b1);
        idle(4);
        send_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (send !== 1'b1 || data !== 32'(q[0])) begin
                errors++; $display("FAIL b2b_%0d got send=%b data=%h exp 1/%h", i, send, data, q[0]);
            end
            void'(q.pop_front());
            @(negedge clk);
        end
        send_ack = 1'b0;
        checks++; if (send !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b exp 0", send); end
    endtask

    task automatic test_overrun();
        for (int i = 0; i <= 16; i++) frame(8'(i), 1'b1);
        idle(4);
        checks++; if (overrun !== m_ovr) begin errors++; $display("FAIL ovr_set got %b exp %b", overrun, m_ovr); end
        checks++; if (framing_error !== 1'b0) begin errors++; $display("FAIL ovr_fe got %b exp 0", framing_error); end
        send_ack = 1'b1;
        for (int i = 0; i < int'(DEPTH) + 1; i++) begin
            checks++;
            if (send !== (q.size() != 0)) begin
                errors++; $display("FAIL ovr_send_%0d got %b exp %b", i, send, q.size() != 0);
            end
            if (q.size() != 0) begin
                checks++;
                if (data !== 32'(q[0])) begin
                    errors++; $display("FAIL ovr_data_%0d got %h exp %h", i, data, q[0]);
                end
                void'(q.pop_front());
            end
            @(negedge clk);
        end
        send_ack = 1'b0;
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b exp 1", overrun); end
        pulse_clear();
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b exp 0", overrun); end
    endtask

    task automatic test_break();
        send_frame(8'h55, 1'b0);
        m_fe = 1'b1;
        rx = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i % 25 == 24) begin
                checks++;
                if (send !== 1'b0 || framing_error !== 1'b1) begin
                    errors++; $display("FAIL break_%0d got send=%b fe=%b exp 0/1", i, send, framing_error);
                end
            end
        end
        idle(4);
        frame(8'h31, 1'b1);
        idle(4);
        checks++;
        if (send !== 1'b1 || data !== 32'h31) begin
            errors++; $display("FAIL after_break got send=%b data=%h exp 1/00000031", send, data);
        end
        send_ack = 1'b1;
        @(negedge clk);
        send_ack = 1'b0;
        void'(q.pop_front());
        pulse_clear();
        checks++; if (framing_error !== 1'b0) begin errors++; $display("FAIL fe_clear got %b exp 0", framing_error); end
    endtask

    task automatic test_glitch();
        rx = 1'b0;
        @(negedge clk);
        idle(30);
        checks++;
        if (send !== 1'b0 || overrun !== 1'b0 || framing_error !== 1'b0) begin
            errors++; $display("FAIL glitch got send=%b ovr=%b fe=%b exp 0/0/0", send, overrun, framing_error);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b = 8'hA5;
        frame(8'h22, 1'b1);
        frame(8'h11, 1'b0);
        idle(4);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = b[3];
        @(negedge clk);
        reset = 1'b1;
        rx = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (send !== 1'b0 || data !== 32'h0 || overrun !== 1'b0 || framing_error !== 1'b0) begin
                errors++; $display("FAIL midrst_%0d got send=%b data=%h ovr=%b fe=%b exp all 0",
                                   i, send, data, overrun, framing_error);
            end
        end
        reset = 1'b0;
        q.delete();
        m_ovr = 1'b0;
        m_fe  = 1'b0;
        idle(4);
        frame(8'h3C, 1'b1);
        idle(4);
        checks++;
        if (send !== 1'b1 || data !== 32'h3C) begin
            errors++; $display("FAIL post_rst got send=%b data=%h exp 1/0000003c", send, data);
        end
        send_ack = 1'b1;
        @(negedge clk);
        send_ack = 1'b0;
        void'(q.pop_front());
        checks++; if (send !== 1'b0) begin errors++; $display("FAIL post_rst_pop got %b exp 0", send); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            int n = $urandom_range(1, 20);
            int budget = 400;
            for (int i = 0; i < n; i++) frame(8'($urandom), $urandom_range(0, 7) != 0);
            idle(4);
            checks++; if (overrun !== m_ovr) begin errors++; $display("FAIL rnd%0d_ovr got %b exp %b", r, overrun, m_ovr); end
            checks++; if (framing_error !== m_fe) begin errors++; $display("FAIL rnd%0d_fe got %b exp %b", r, framing_error, m_fe); end
            while (budget > 0) begin
                logic ack;
                checks++;
                if (send !== (q.size() != 0)) begin
                    errors++; $display("FAIL rnd%0d_send got %b exp %b", r, send, q.size() != 0);
                end
                if (q.size() == 0) break;
                checks++;
                if (data !== 32'(q[0])) begin
                    errors++; $display("FAIL rnd%0d_data got %h exp %h", r, data, q[0]);
                end
                ack = 1'($urandom_range(0, 1));
                send_ack = ack;
                @(negedge clk);
                if (ack) void'(q.pop_front());
                budget--;
            end
            send_ack = 1'b0;
            if (budget == 0) begin
                checks++; errors++; $display("FAIL rnd%0d_drain got timeout exp empty", r);
                q.delete();
            end
            pulse_clear();
            checks++;
            if (overrun !== 1'b0 || framing_error !== 1'b0) begin
                errors++; $display("FAIL rnd%0d_clear got ovr=%b fe=%b exp 0/0", r, overrun, framing_error);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        rx = 1'b1;
        send_ack = 1'b0;
        clear_errors = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b0;
        idle(4);
        test_single();
        test_back_to_back();
        test_overrun();
        test_break();
        test_glitch();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
